bounce_motion_ctrl: RTL and testbench

Per-frame motion sequencer for the bouncing-box screensaver. On each frame tick it steps the box position one axis at a time, detects screen-edge hits, reflects velocity, and cycles the box colour. It sits between the video timer's frame strobe and the image renderer, which consumes box_x, box_y and color. It replaces ad-hoc per-frame update logic with a sequenced, configurable controller.

---
 rtl/bounce_motion_ctrl.sv | 126 ++++++++++++
 tb/tb_bounce_motion_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bounce_motion_ctrl.sv
// bounce_motion_ctrl: per-frame bouncing-box sequencer that steps x then y, reflects at screen edges and cycles colour.
// The new position and colour are committed together, so the renderer never sees a half-updated box.
module bounce_motion_ctrl #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int BOX_WIDTH     = 100,
    parameter int BOX_HEIGHT    = 100,
    parameter int INIT_X        = 50,
    parameter int INIT_Y        = 50,
    parameter int INIT_XV       = 2,
    parameter int INIT_YV       = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             frame_tick,
    input  logic                             enable,
    input  logic                             cfg_load,
    input  logic [3:0]                       speed_x,
    input  logic [3:0]                       speed_y,
    output logic [$clog2(SCREEN_WIDTH)-1:0]  box_x,
    output logic [$clog2(SCREEN_HEIGHT)-1:0] box_y,
    output logic [2:0]                       color,
    output logic                             busy,
    output logic                             update_done,
    output logic [15:0]                      bounce_count,
    output logic                             overrun
);
    localparam int XW = $clog2(SCREEN_WIDTH);
    localparam int YW = $clog2(SCREEN_HEIGHT);
    localparam logic [XW:0] MAX_X = (XW+1)'(SCREEN_WIDTH - BOX_WIDTH);
    localparam logic [YW:0] MAX_Y = (YW+1)'(SCREEN_HEIGHT - BOX_HEIGHT);

    typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y, COMMIT} state_t;
    state_t r_state, w_next;

    logic [XW-1:0] r_sx;
    logic [YW-1:0] r_sy;
    logic          r_dir_x, r_dir_y, r_hit_x, r_hit_y;
    logic [3:0]    r_mag_x, r_mag_y, r_pend_x, r_pend_y;
    logic          r_pend_vld;
    logic [XW:0]   w_tx;
    logic [YW:0]   w_ty;
    logic          w_hit_x, w_hit_y;
    logic [XW-1:0] w_nx;
    logic [YW-1:0] w_ny;

    // Zero magnitude never reports a hit, so a parked box keeps its direction.
    assign w_tx    = {1'b0, box_x} + (XW+1)'(r_mag_x);
    assign w_ty    = {1'b0, box_y} + (YW+1)'(r_mag_y);
    assign w_hit_x = (r_mag_x != 4'd0) && (r_dir_x ? (w_tx >= MAX_X) : (box_x <= XW'(r_mag_x)));
    assign w_hit_y = (r_mag_y != 4'd0) && (r_dir_y ? (w_ty >= MAX_Y) : (box_y <= YW'(r_mag_y)));
    assign w_nx    = r_dir_x ? (w_hit_x ? MAX_X[XW-1:0] : w_tx[XW-1:0]) : (w_hit_x ? '0 : box_x - XW'(r_mag_x));
    assign w_ny    = r_dir_y ? (w_hit_y ? MAX_Y[YW-1:0] : w_ty[YW-1:0]) : (w_hit_y ? '0 : box_y - YW'(r_mag_y));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (frame_tick && enable) ? MOVE_X : IDLE;
            MOVE_X:  w_next = MOVE_Y;
            MOVE_Y:  w_next = COMMIT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box_x        <= XW'(INIT_X);
            box_y        <= YW'(INIT_Y);
            r_sx         <= XW'(INIT_X);
            r_sy         <= YW'(INIT_Y);
            r_dir_x      <= 1'b1;
            r_dir_y      <= 1'b1;
            r_hit_x      <= 1'b0;
            r_hit_y      <= 1'b0;
            r_mag_x      <= 4'(INIT_XV);
            r_mag_y      <= 4'(INIT_YV);
            r_pend_x     <= 4'd0;
            r_pend_y     <= 4'd0;
            r_pend_vld   <= 1'b0;
            color        <= 3'b111;
            busy         <= 1'b0;
            update_done  <= 1'b0;
            bounce_count <= 16'd0;
            overrun      <= 1'b0;
        end else begin
            busy        <= (w_next != IDLE);
            update_done <= (r_state == COMMIT);
            overrun     <= overrun | (frame_tick && enable && r_state != IDLE);
            if (r_state == IDLE && cfg_load) begin
                r_mag_x <= speed_x;
                r_mag_y <= speed_y;
            end
            if ((r_state == MOVE_X || r_state == MOVE_Y) && cfg_load) begin
                r_pend_x   <= speed_x;
                r_pend_y   <= speed_y;
                r_pend_vld <= 1'b1;
            end
            if (r_state == MOVE_X) begin
                r_sx    <= w_nx;
                r_hit_x <= w_hit_x;
                r_dir_x <= r_dir_x ^ w_hit_x;
            end
            if (r_state == MOVE_Y) begin
                r_sy    <= w_ny;
                r_hit_y <= w_hit_y;
                r_dir_y <= r_dir_y ^ w_hit_y;
            end
            if (r_state == COMMIT) begin
                box_x      <= r_sx;
                box_y      <= r_sy;
                r_pend_vld <= 1'b0;
                r_mag_x    <= cfg_load ? speed_x : (r_pend_vld ? r_pend_x : r_mag_x);
                r_mag_y    <= cfg_load ? speed_y : (r_pend_vld ? r_pend_y : r_mag_y);
                if (r_hit_x || r_hit_y) begin
                    color        <= (color == 3'd7) ? 3'd1 : color + 3'd1;
                    bounce_count <= (bounce_count == 16'hFFFF) ? bounce_count : bounce_count + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bounce_motion_ctrl.sv
// tb_bounce_motion_ctrl: directed bench for bounce_motion_ctrl with hand-computed positions.
// Stimulus changes and sampling both happen on the falling edge, away from the active edge.
module tb_bounce_motion_ctrl;
    logic        clk = 0, rst_n = 0, frame_tick = 0, enable = 1, cfg_load = 0;
    logic [3:0]  speed_x = 0, speed_y = 0;
    logic [9:0]  box_x;
    logic [8:0]  box_y;
    logic [2:0]  color;
    logic        busy, update_done, overrun;
    logic [15:0] bounce_count;
    int vecs = 0, errs = 0;

    bounce_motion_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable), .cfg_load(cfg_load),
        .speed_x(speed_x), .speed_y(speed_y), .box_x(box_x), .box_y(box_y), .color(color),
        .busy(busy), .update_done(update_done), .bounce_count(bounce_count), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic do_frame();
        frame_tick = 1;
        @(negedge clk);
        frame_tick = 0;
        for (int i = 0; i < 8 && !update_done; i++) @(negedge clk);
        vecs++; if (update_done !== 1'b1) begin errs++; $display("FAIL frame_timeout update_done=%b required 1", update_done); end
    endtask

    task automatic do_cfg(input logic [3:0] sx, input logic [3:0] sy);
        cfg_load = 1; speed_x = sx; speed_y = sy;
        @(negedge clk);
        cfg_load = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vecs++; if (box_x !== 10'd50) begin errs++; $display("FAIL rst_x got %0d exp 50", box_x); end
        vecs++; if (box_y !== 9'd50) begin errs++; $display("FAIL rst_y got %0d exp 50", box_y); end
        vecs++; if (color !== 3'd7) begin errs++; $display("FAIL rst_color got %0d exp 7", color); end
        vecs++; if ({busy, update_done, overrun} !== 3'b000) begin errs++; $display("FAIL rst_flags got %b exp 000", {busy, update_done, overrun}); end
        vecs++; if (bounce_count !== 16'd0) begin errs++; $display("FAIL rst_bounce got %0d exp 0", bounce_count); end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_latency();
        int bc = 0, dc = -1;
        frame_tick = 1;
        @(negedge clk);
        frame_tick = 0;
        for (int c = 1; c <= 6; c++) begin
            if (busy) bc++;
            if (update_done && dc < 0) dc = c;
            @(negedge clk);
        end
        vecs++; if (bc !== 3) begin errs++; $display("FAIL lat_busy got %0d cycles exp 3", bc); end
        vecs++; if (dc !== 4) begin errs++; $display("FAIL lat_done got cycle %0d exp 4", dc); end
        vecs++; if (box_x !== 10'd52 || box_y !== 9'd51) begin errs++; $display("FAIL lat_pos got %0d,%0d exp 52,51", box_x, box_y); end
        vecs++; if (color !== 3'd7 || update_done !== 1'b0) begin errs++; $display("FAIL lat_color got %0d/%b exp 7/0", color, update_done); end
    endtask

    task automatic test_right_edge();
        repeat (243) do_frame();
        vecs++; if (box_x !== 10'd538 || box_y !== 9'd294) begin errs++; $display("FAIL run_pos got %0d,%0d exp 538,294", box_x, box_y); end
        do_cfg(4'd5, 4'd1);
        do_frame();
        vecs++; if (box_x !== 10'd540 || box_y !== 9'd295) begin errs++; $display("FAIL redge_pos got %0d,%0d exp 540,295", box_x, box_y); end
        vecs++; if (color !== 3'd1 || bounce_count !== 16'd1) begin errs++; $display("FAIL redge_col got %0d/%0d exp 1/1", color, bounce_count); end
        do_frame();
        vecs++; if (box_x !== 10'd535 || color !== 3'd1) begin errs++; $display("FAIL redge_back got %0d/%0d exp 535/1", box_x, color); end
    endtask

    task automatic test_left_edge();
        do_cfg(4'd4, 4'd0);
        repeat (133) do_frame();
        vecs++; if (box_x !== 10'd3 || box_y !== 9'd296) begin errs++; $display("FAIL lrun_pos got %0d,%0d exp 3,296", box_x, box_y); end
        do_cfg(4'd5, 4'd0);
        do_frame();
        vecs++; if (box_x !== 10'd0 || color !== 3'd2 || bounce_count !== 16'd2) begin errs++; $display("FAIL ledge got x%0d c%0d b%0d exp 0/2/2", box_x, color, bounce_count); end
        do_frame();
        vecs++; if (box_x !== 10'd5 || color !== 3'd2) begin errs++; $display("FAIL ledge_back got %0d/%0d exp 5/2", box_x, color); end
    endtask

    task automatic test_corner();
        do_cfg(4'd13, 4'd2);
        repeat (41) do_frame();
        vecs++; if (box_x !== 10'd538 || box_y !== 9'd378) begin errs++; $display("FAIL crun_pos got %0d,%0d exp 538,378", box_x, box_y); end
        do_cfg(4'd2, 4'd2);
        do_frame();
        vecs++; if (box_x !== 10'd540 || box_y !== 9'd380) begin errs++; $display("FAIL corner_pos got %0d,%0d exp 540,380", box_x, box_y); end
        vecs++; if (color !== 3'd3 || bounce_count !== 16'd3) begin errs++; $display("FAIL corner_col got %0d/%0d exp 3/3", color, bounce_count); end
    endtask

    task automatic test_zero_speed();
        do_cfg(4'd0, 4'd0);
        do_frame();
        vecs++; if (box_x !== 10'd540 || box_y !== 9'd380) begin errs++; $display("FAIL zero_pos got %0d,%0d exp 540,380", box_x, box_y); end
        vecs++; if (color !== 3'd3 || bounce_count !== 16'd3) begin errs++; $display("FAIL zero_col got %0d/%0d exp 3/3", color, bounce_count); end
    endtask

    task automatic test_overrun();
        int dones = 0;
        do_cfg(4'd2, 4'd1);
        vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL ovr_pre got %b exp 0", overrun); end
        frame_tick = 1;
        @(negedge clk);
        @(negedge clk);
        frame_tick = 0;
        for (int c = 0; c < 10; c++) begin
            if (update_done) dones++;
            @(negedge clk);
        end
        vecs++; if (dones !== 1) begin errs++; $display("FAIL ovr_dones got %0d exp 1", dones); end
        vecs++; if (overrun !== 1'b1) begin errs++; $display("FAIL ovr_flag got %b exp 1", overrun); end
        vecs++; if (box_x !== 10'd538 || box_y !== 9'd379) begin errs++; $display("FAIL ovr_pos got %0d,%0d exp 538,379", box_x, box_y); end
        enable = 0;
        frame_tick = 1;
        @(negedge clk);
        frame_tick = 0;
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            if (update_done || busy) dones++;
            @(negedge clk);
        end
        enable = 1;
        vecs++; if (dones !== 0) begin errs++; $display("FAIL dis_activity got %0d exp 0", dones); end
        vecs++; if (box_x !== 10'd538 || overrun !== 1'b1) begin errs++; $display("FAIL dis_state got %0d/%b exp 538/1", box_x, overrun); end
    endtask

    task automatic test_pending_cfg();
        frame_tick = 1;
        @(negedge clk);
        frame_tick = 0; enable = 0;
        cfg_load = 1; speed_x = 4'd4; speed_y = 4'd1;
        @(negedge clk);
        speed_x = 4'd6;
        @(negedge clk);
        cfg_load = 0; enable = 1;
        for (int i = 0; i < 6 && !update_done; i++) @(negedge clk);
        vecs++; if (update_done !== 1'b1 || box_x !== 10'd536 || box_y !== 9'd378) begin errs++; $display("FAIL pend_cur got d%b %0d,%0d exp 1 536,378", update_done, box_x, box_y); end
        do_frame();
        vecs++; if (box_x !== 10'd530 || box_y !== 9'd377) begin errs++; $display("FAIL pend_next got %0d,%0d exp 530,377", box_x, box_y); end
    endtask

    task automatic test_back_to_back();
        cfg_load = 1; speed_x = 4'd1; speed_y = 4'd1;
        frame_tick = 1;
        @(negedge clk);
        cfg_load = 0; frame_tick = 0;
        for (int i = 0; i < 8 && !update_done; i++) @(negedge clk);
        vecs++; if (box_x !== 10'd529 || box_y !== 9'd376) begin errs++; $display("FAIL cfgtick_pos got %0d,%0d exp 529,376", box_x, box_y); end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        frame_tick = 1;
        @(negedge clk);
        frame_tick = 0;
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        vecs++; if (box_x !== 10'd50 || box_y !== 9'd50 || color !== 3'd7) begin errs++; $display("FAIL amid_pos got %0d,%0d c%0d exp 50,50 c7", box_x, box_y, color); end
        vecs++; if ({busy, overrun} !== 2'b00 || bounce_count !== 16'd0) begin errs++; $display("FAIL amid_flags got %b b%0d exp 00 b0", {busy, overrun}, bounce_count); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (update_done) dones++;
        end
        rst_n = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (update_done) dones++;
        end
        vecs++; if (dones !== 0) begin errs++; $display("FAIL amid_done got %0d pulses exp 0", dones); end
        do_frame();
        vecs++; if (box_x !== 10'd52 || box_y !== 9'd51) begin errs++; $display("FAIL amid_resume got %0d,%0d exp 52,51", box_x, box_y); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_right_edge();
        test_left_edge();
        test_corner();
        test_zero_speed();
        test_overrun();
        test_pending_cfg();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
